// File: rtl/moore_seq_detector.sv
// Moore-type serial pattern detector with a KMP transition table built at
// elaboration, optional overlapping matches, a valid qualifier and a
// saturating match counter.
// Optional feature macro: MOORE_SEQ_DET_STICKY_EN (enables the sticky 'seen' flag).
module moore_seq_detector #(
    parameter int unsigned           PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]    PATTERN = 4'b1011,
    parameter bit                    OVERLAP = 1'b1,
    parameter int unsigned           CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             seen
);

    localparam int unsigned SW   = $clog2(PAT_LEN + 1);
    localparam int unsigned NENT = 2 ** (SW + 1);

    localparam logic [SW-1:0]    S_IDLE  = '0;
    localparam logic [SW-1:0]    S_ACC   = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Table entry index is {state, din}; unused state encodings map to S0.
    typedef logic [SW-1:0] nxt_tbl_t [NENT];

    // Longest suffix of (first k pattern bits, b) that is also a pattern prefix.
    function automatic logic [SW-1:0] kmp_next(input int unsigned k, input logic b);
        int unsigned best;
        logic        ok;
        logic        sb;
        int unsigned idx;
        best = 0;
        for (int unsigned j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int unsigned m = 0; m < j; m++) begin
                    idx = k + 1 - j + m;
                    sb  = (idx == k) ? b : PATTERN[PAT_LEN-1-idx];
                    if (sb != PATTERN[PAT_LEN-1-m]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return SW'(best);
    endfunction

    // Full next-state table; the accepting state restarts from S0 without overlap.
    function automatic nxt_tbl_t build_tbl();
        nxt_tbl_t    tbl;
        int unsigned k;
        int unsigned kk;
        for (int unsigned e = 0; e < NENT; e++) begin
            k = e / 2;
            if (k <= PAT_LEN) begin
                kk     = (k == PAT_LEN && !OVERLAP) ? 0 : k;
                tbl[e] = kmp_next(kk, (e % 2) == 1);
            end else begin
                tbl[e] = S_IDLE;
            end
        end
        return tbl;
    endfunction

    localparam nxt_tbl_t NXT_TBL = build_tbl();

    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q;
    logic             dout_q;
    logic             hit_c;
    logic [SW:0]      tbl_idx_c;

    // Next state, match pulse and counter update; clear overrides a valid bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hit_c     = 1'b0;
        tbl_idx_c = {state_q, din};
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (din_valid) begin
            state_d = NXT_TBL[tbl_idx_c];
            if (state_d == S_ACC) begin
                hit_c = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State, counter and registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= (cnt_d == CNT_MAX);
            dout_q  <= (state_d == S_ACC);
        end
    end

    assign dout      = dout_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

`ifdef MOORE_SEQ_DET_STICKY_EN
    logic seen_q;

    // Sticky flag: set on any match, cleared only by clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else if (clear) begin
            seen_q <= 1'b0;
        end else if (hit_c) begin
            seen_q <= 1'b1;
        end
    end

    assign seen = seen_q;
`else
    assign seen = 1'b0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: a shared-stimulus vector table for the
// 1011 pattern (overlap and non-overlap instances) plus hand sequences for
// saturation and asynchronous reset.
module tb_moore_seq_detector;

`ifdef MOORE_SEQ_DET_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic din_valid;
    logic din;
    logic clear;

    logic       dout_p, sat_p, seen_p;
    logic [7:0] cnt_p;
    logic       dout_n, sat_n, seen_n;
    logic [7:0] cnt_n;
    logic       dout_s, sat_s, seen_s;
    logic [1:0] cnt_s;

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_p (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
        .dout(dout_p), .match_cnt(cnt_p), .cnt_sat(sat_p), .seen(seen_p)
    );

    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_n (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
        .dout(dout_n), .match_cnt(cnt_n), .cnt_sat(sat_n), .seen(seen_n)
    );

    moore_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clear(clear),
        .dout(dout_s), .match_cnt(cnt_s), .cnt_sat(sat_s), .seen(seen_s)
    );

    typedef struct {
        bit clr;
        bit vld;
        bit d;
        bit dout_p;
        int cnt_p;
        bit dout_n;
        int cnt_n;
        bit seen;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input bit clr, input bit vld, input bit d);
        @(negedge clk);
        clear     = clr;
        din_valid = vld;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    int sat_cnt_exp [8];

    initial begin
        //             clr vld d  dout_p cnt_p dout_n cnt_n seen
        vecs[0]  = '{0, 1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 1, 1, 1, 1, 1};
        vecs[4]  = '{0, 1, 0, 0, 1, 0, 1, 1};
        vecs[5]  = '{0, 1, 1, 0, 1, 0, 1, 1};
        vecs[6]  = '{0, 1, 1, 1, 2, 0, 1, 1};
        vecs[7]  = '{0, 1, 0, 0, 2, 0, 1, 1};
        vecs[8]  = '{0, 1, 1, 0, 2, 0, 1, 1};
        vecs[9]  = '{0, 1, 1, 1, 3, 1, 2, 1};
        vecs[10] = '{0, 0, 0, 1, 3, 1, 2, 1};
        vecs[11] = '{0, 0, 1, 1, 3, 1, 2, 1};
        vecs[12] = '{0, 1, 1, 0, 3, 0, 2, 1};
        vecs[13] = '{0, 0, 0, 0, 3, 0, 2, 1};
        vecs[14] = '{0, 0, 1, 0, 3, 0, 2, 1};
        vecs[15] = '{0, 0, 0, 0, 3, 0, 2, 1};
        vecs[16] = '{0, 1, 0, 0, 3, 0, 2, 1};
        vecs[17] = '{0, 1, 1, 0, 3, 0, 2, 1};
        vecs[18] = '{0, 1, 1, 1, 4, 1, 3, 1};
        vecs[19] = '{0, 1, 1, 0, 4, 0, 3, 1};
        vecs[20] = '{0, 1, 0, 0, 4, 0, 3, 1};
        vecs[21] = '{0, 1, 1, 0, 4, 0, 3, 1};
        vecs[22] = '{1, 1, 1, 0, 0, 0, 0, 0};
        vecs[23] = '{0, 1, 1, 0, 0, 0, 0, 0};
        vecs[24] = '{0, 1, 1, 0, 0, 0, 0, 0};
        vecs[25] = '{0, 1, 0, 0, 0, 0, 0, 0};
        vecs[26] = '{0, 1, 1, 0, 0, 0, 0, 0};
        vecs[27] = '{0, 1, 1, 1, 1, 1, 1, 1};
        vecs[28] = '{0, 1, 0, 0, 1, 0, 1, 1};
        vecs[29] = '{0, 1, 0, 0, 1, 0, 1, 1};

        sat_cnt_exp = '{0, 0, 0, 1, 2, 3, 3, 3};

        // Reset held with random input activity.
        rst_n     = 1'b0;
        clear     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din_valid = 1'($urandom);
            din       = 1'($urandom);
        end
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dout", 0, 32'(dout_p), 32'd0);
        check("rst_cnt",  0, 32'(cnt_p),  32'd0);
        check("rst_sat",  0, 32'(sat_p),  32'd0);
        check("rst_seen", 0, 32'(seen_p), 32'd0);
        check("rst_cnt_s", 0, 32'(cnt_s), 32'd0);

        // Table-driven main sequence.
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].d);
            check("dout_p", i, 32'(dout_p), 32'(vecs[i].dout_p));
            check("cnt_p",  i, 32'(cnt_p),  32'(vecs[i].cnt_p));
            check("sat_p",  i, 32'(sat_p),  32'd0);
            check("seen_p", i, 32'(seen_p), 32'(STICKY & vecs[i].seen));
            check("dout_n", i, 32'(dout_n), 32'(vecs[i].dout_n));
            check("cnt_n",  i, 32'(cnt_n),  32'(vecs[i].cnt_n));
            check("seen_n", i, 32'(seen_n), 32'(STICKY & vecs[i].seen));
        end

        // Saturation: pattern 1111, 2-bit counter, eight consecutive ones.
        step(1'b1, 1'b0, 1'b0);
        check("sat_clr_cnt", 0, 32'(cnt_s), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("dout_s", i, 32'(dout_s), (i >= 3) ? 32'd1 : 32'd0);
            check("cnt_s",  i, 32'(cnt_s),  32'(sat_cnt_exp[i]));
            check("sat_s",  i, 32'(sat_s),  (sat_cnt_exp[i] == 3) ? 32'd1 : 32'd0);
        end
        // Counter holds at its ceiling while the match persists.
        step(1'b0, 1'b0, 1'b0);
        check("cnt_s_hold", 0, 32'(cnt_s),  32'd3);
        check("dout_s_hold", 0, 32'(dout_s), 32'd1);

        // Asynchronous reset mid-pattern (S3 after 1011,0,1) with a nonzero count.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("pre_rst_cnt",  0, 32'(cnt_p),  32'd1);
        check("pre_rst_seen", 0, 32'(seen_p), 32'(STICKY));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_dout", 0, 32'(dout_p), 32'd0);
        check("async_cnt",  0, 32'(cnt_p),  32'd0);
        check("async_sat_s", 0, 32'(sat_s), 32'd0);
        check("async_cnt_s", 0, 32'(cnt_s), 32'd0);
        check("async_seen", 0, 32'(seen_p), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // From S0, a single 1 must not complete a match.
        step(1'b0, 1'b1, 1'b1);
        check("post_rst_dout", 0, 32'(dout_p), 32'd0);
        check("post_rst_cnt",  0, 32'(cnt_p),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
